// File: rtl/alu_wide_sequencer_pkg.sv
// Shared types for the wide ALU sequencer.
//   op_mne      : 3-bit ALU/request opcode mnemonics
//   seq_state_t : sequencer FSM state
//   kSHAMT1     : shift amount byte fed to the ALU for single-bit shifts
package alu_wide_sequencer_pkg;

  typedef enum logic [2:0] {
    kADD  = 3'd0,
    kSUB  = 3'd1,
    kSHL  = 3'd2,
    kSHR  = 3'd3,
    kXOR  = 3'd4,
    kAND  = 3'd5,
    kOR   = 3'd6,
    kPASS = 3'd7
  } op_mne;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_state_t;

  localparam logic [7:0] kSHAMT1 = 8'd1;

  function automatic logic is_shift(input op_mne op);
    return (op == kSHL) || (op == kSHR);
  endfunction

endpackage

// File: rtl/alu_wide_sequencer_if.sv
// Request/response handshake bundle between the control unit and the sequencer.
//   master : control unit side (drives req_*, rsp_ready)
//   slave  : sequencer side (drives req_ready, rsp_*)
interface alu_wide_sequencer_if
  import alu_wide_sequencer_pkg::*;
#(
  parameter int NBYTES = 2
);
  localparam int W = 8 * NBYTES;

  logic         req_valid;
  logic         req_ready;
  op_mne        req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_flag;
  logic         rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flag, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flag, rsp_zero
  );

endinterface

// File: rtl/alu_wide_sequencer_seq_byte_mux.sv
// Byte lane selector for the wide sequencer.
//   a, b      : captured wide operands
//   idx       : active byte slot
//   invert_b  : present ~B byte (subtract issued as add)
//   force_b   : present kSHAMT1 instead of B (shifts)
//   res_byte  : ALU result byte for slot idx
//   data_in   : current wide result, data_out = data_in with slot idx replaced
//   a_byte, b_byte : operand bytes to the ALU
module seq_byte_mux
  import alu_wide_sequencer_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic [2:0]          idx,
  input  logic                invert_b,
  input  logic                force_b,
  input  logic [7:0]          res_byte,
  input  logic [8*NBYTES-1:0] data_in,
  output logic [7:0]          a_byte,
  output logic [7:0]          b_byte,
  output logic [8*NBYTES-1:0] data_out
);

  logic [7:0] b_raw;

  always_comb begin
    a_byte   = '0;
    b_raw    = '0;
    data_out = data_in;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == 3'(i)) begin
        a_byte              = a[8*i +: 8];
        b_raw               = b[8*i +: 8];
        data_out[8*i +: 8]  = res_byte;
      end
    end
    if (force_b)       b_byte = kSHAMT1;
    else if (invert_b) b_byte = ~b_raw;
    else               b_byte = b_raw;
  end

endmodule

// File: rtl/alu_wide_sequencer.sv
// Wide (NBYTES x 8-bit) operation sequencer driving an external 8-bit ALU.
// Accepts one request on bus (valid/ready), issues one byte per cycle with
// carry/shift chaining, returns the wide result and flags on bus (valid/ready).
//   clk, reset  : clock, synchronous active-high reset
//   bus         : request/response handshake (slave modport)
//   alu_a/alu_b/alu_op/alu_cin/alu_sin : byte operation to the ALU
//   alu_out/alu_cout/alu_sout/alu_zero : ALU result byte and flags
// Option macro ALU_SEQ_OVERLAP_EN: accept the next request in the same cycle
// the response is taken, removing the idle bubble between requests.
module alu_wide_sequencer
  import alu_wide_sequencer_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_wide_sequencer_if.slave     bus,
  output logic [7:0]              alu_a,
  output logic [7:0]              alu_b,
  output op_mne                   alu_op,
  output logic                    alu_cin,
  output logic                    alu_sin,
  input  logic [7:0]              alu_out,
  input  logic                    alu_cout,
  input  logic                    alu_sout,
  input  logic                    alu_zero
);

  localparam int         W    = 8 * NBYTES;
  localparam logic [2:0] LAST = 3'(NBYTES - 1);

  seq_state_t   state_q, state_d;
  logic [2:0]   cnt_q, idx;
  op_mne        op_q;
  logic [W-1:0] a_q, b_q, data_q, data_next;
  logic         cin_q, chain_q, zero_q, chain_d;
  logic         req_ready, rsp_valid, accept, running, first, last;
  logic [7:0]   a_byte, b_byte;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
`ifdef ALU_SEQ_OVERLAP_EN
        req_ready = bus.rsp_ready;
        if (bus.rsp_ready) state_d = bus.req_valid ? S_RUN : S_IDLE;
`else
        if (bus.rsp_ready) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept        = bus.req_valid && req_ready;
  assign running       = (state_q == S_RUN);
  assign first         = (cnt_q == 3'd0);
  assign last          = (cnt_q == LAST);
  // Right shifts must walk MSB first so the shift-in bit enters at the top.
  assign idx           = (op_q == kSHR) ? (LAST - cnt_q) : cnt_q;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flag  = chain_q;
  assign bus.rsp_zero  = zero_q;

  seq_byte_mux #(.NBYTES(NBYTES)) u_byte_mux (
    .a        (a_q),
    .b        (b_q),
    .idx      (idx),
    .invert_b (op_q == kSUB),
    .force_b  (is_shift(op_q)),
    .res_byte (alu_out),
    .data_in  (data_q),
    .a_byte   (a_byte),
    .b_byte   (b_byte),
    .data_out (data_next)
  );

  always_comb begin
    alu_op  = kPASS;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_sin = 1'b0;
    chain_d = 1'b0;
    if (running) begin
      alu_a  = a_byte;
      alu_b  = b_byte;
      alu_op = (op_q == kSUB) ? kADD : op_q;
      case (op_q)
        kADD: begin
          alu_cin = first ? cin_q : chain_q;
          chain_d = alu_cout;
        end
        kSUB: begin
          // Two's complement: A + ~B + 1 on the first byte.
          alu_cin = first ? 1'b1 : chain_q;
          chain_d = alu_cout;
        end
        kSHL, kSHR: begin
          alu_sin = first ? cin_q : chain_q;
          chain_d = alu_sout;
        end
        default: chain_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      op_q    <= kPASS;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      chain_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_op;
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        cin_q <= bus.req_cin;
        cnt_q <= '0;
      end
      if (running) begin
        data_q  <= data_next;
        chain_q <= chain_d;
        zero_q  <= (first || zero_q) && alu_zero;
        cnt_q   <= last ? 3'd0 : cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench for alu_wide_sequencer (NBYTES=2) with a behavioural
// 8-bit ALU and a whole-word reference model.
module tb_alu_wide_sequencer;
  import alu_wide_sequencer_pkg::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_a, alu_b, alu_out;
  op_mne      alu_op;
  logic       alu_cin, alu_sin, alu_cout, alu_sout, alu_zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_wide_sequencer_if #(.NBYTES(NB)) bus ();

  alu_wide_sequencer #(.NBYTES(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_cin  (alu_cin),
    .alu_sin  (alu_sin),
    .alu_out  (alu_out),
    .alu_cout (alu_cout),
    .alu_sout (alu_sout),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit combinational ALU.
  always_comb begin
    logic [8:0] s;
    s        = '0;
    alu_out  = '0;
    alu_cout = 1'b0;
    alu_sout = 1'b0;
    case (alu_op)
      kADD: begin
        s        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_out  = s[7:0];
        alu_cout = s[8];
      end
      kSHL: begin
        alu_out  = {alu_a[6:0], alu_sin};
        alu_sout = alu_a[7];
      end
      kSHR: begin
        alu_out  = {alu_sin, alu_a[7:1]};
        alu_sout = alu_a[0];
      end
      kXOR:    alu_out = alu_a ^ alu_b;
      kAND:    alu_out = alu_a & alu_b;
      kOR:     alu_out = alu_a | alu_b;
      default: alu_out = alu_b;
    endcase
    alu_zero = (alu_out == 8'd0);
  end

  // Whole-word reference: returns {flag, data}.
  function automatic logic [W:0] ref_calc(input op_mne op, input logic [W-1:0] a, b,
                                          input logic cin);
    case (op)
      kADD:    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      kSUB:    return {(a >= b), a - b};
      kSHL:    return {a[W-1], a[W-2:0], cin};
      kSHR:    return {a[0], cin, a[W-1:1]};
      kXOR:    return {1'b0, a ^ b};
      kAND:    return {1'b0, a & b};
      kOR:     return {1'b0, a | b};
      default: return {1'b0, b};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input op_mne op, input logic [W-1:0] a, b, input logic cin,
                         input int stall, input logic pulse);
    logic [W:0] exp;
    int guard;
    int lat;
    exp = ref_calc(op, a, b, cin);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.rsp_ready = 1'b0;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("accept_wait", 64'(guard < 50), 64'd1);
    step();
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("latency", 64'(lat), 64'(NB));
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = pulse && (i % 2 == 0);
      bus.req_a     = W'($urandom);
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_data", 64'(bus.rsp_data), 64'(exp[W-1:0]));
      step();
    end
    bus.req_valid = 1'b0;
    chk("rsp_data", 64'(bus.rsp_data), 64'(exp[W-1:0]));
    chk("rsp_flag", 64'(bus.rsp_flag), 64'(exp[W]));
    chk("rsp_zero", 64'(bus.rsp_zero), 64'(exp[W-1:0] == '0));
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_release", 64'(bus.rsp_valid), 64'd0);
    chk("idle_ready", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = kPASS;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("reset_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_data", 64'(bus.rsp_data), 64'd0);
    chk("reset_flag", 64'(bus.rsp_flag), 64'd0);
    chk("reset_zero", 64'(bus.rsp_zero), 64'd0);
    chk("idle_alu_op", 64'(alu_op), 64'(kPASS));
    chk("idle_alu_a", 64'(alu_a), 64'd0);

    run_req(kADD, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
    run_req(kSUB, 16'h0100, 16'h0001, 1'b0, 0, 1'b0);
    run_req(kSUB, 16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    run_req(kSHL, 16'h8001, 16'h0000, 1'b1, 0, 1'b0);
    run_req(kSHR, 16'h0180, 16'h0000, 1'b1, 0, 1'b0);
    run_req(kXOR, 16'h5A5A, 16'h5A5A, 1'b0, 0, 1'b0);
    run_req(kPASS, 16'h0000, 16'h1234, 1'b0, 0, 1'b0);
    run_req(kADD, 16'hFFFF, 16'h0001, 1'b0, 5, 1'b1);

    // Reset after the first byte of an add discards it.
    bus.req_valid = 1'b1;
    bus.req_op    = kADD;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h4321;
    bus.req_cin   = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid_data", 64'(bus.rsp_data), 64'd0);
    step();
    chk("rst_mid_hold", 64'(bus.rsp_valid), 64'd0);
    run_req(kADD, 16'h1234, 16'h4321, 1'b1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_req(op_mne'($urandom_range(0, 7)), W'($urandom), W'($urandom),
              1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
